textbuf_ctrl: RTL

//  Terminal-style write controller for the text-tile memory feeding the serial LCD text path.
//  - Accepts a character stream over a valid/ready handshake.
//  - Maintains the cursor and handles CR/LF/BS, line wrap and scrolling.
//  - Sequences all writes into the text memory's write port.
//  - Scrolling uses a ring-buffer row offset (out_row_offs), not a memory copy. The display

---
 rtl/textbuf_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/textbuf_ctrl.sv
// Terminal-style write controller for the LCD text-tile memory: cursor, CR/LF/BS, wrap, ring-scroll.
// All outputs registered; a printable char costs accept + one WR cycle, a scroll adds TEXT_COLS clear cycles.
module textbuf_ctrl #(
  parameter int TEXT_COLS = 20,
  parameter int TEXT_ROWS = 6,
  parameter int ADDR_BITS = 7,
  parameter int CHAR_BITS = 8,
  parameter logic [CHAR_BITS-1:0] CLEAR_CHAR = CHAR_BITS'('h20)
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic                         in_char_valid,
  input  logic [CHAR_BITS-1:0]         in_char,
  output logic                         out_char_ready,
  output logic                         out_mem_we,
  output logic [ADDR_BITS-1:0]         out_mem_addr,
  output logic [CHAR_BITS-1:0]         out_mem_data,
  output logic [$clog2(TEXT_COLS)-1:0] out_cursor_x,
  output logic [$clog2(TEXT_ROWS)-1:0] out_cursor_y,
  output logic [$clog2(TEXT_ROWS)-1:0] out_row_offs,
  output logic                         out_busy
);
  localparam int XW    = $clog2(TEXT_COLS);
  localparam int YW    = $clog2(TEXT_ROWS);
  localparam int CELLS = TEXT_COLS * TEXT_ROWS;

  typedef enum logic [1:0] {S_CLR_ALL, S_IDLE, S_WR, S_CLR_LINE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   cnt_q, cnt_d, base_q, base_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d, offs_q, offs_d;
  logic                   scroll_q, scroll_d;
  logic                   ready_q, ready_d, we_q, we_d, busy_q, busy_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [CHAR_BITS-1:0]   data_q, data_d;

  logic                   accept, is_print, is_lf, is_cr, is_bs, at_eol, at_bottom;
  logic [YW-1:0]          offs_inc;

  function automatic logic [ADDR_BITS-1:0] row_base(input logic [YW-1:0] row);
    return ADDR_BITS'(row) * ADDR_BITS'(TEXT_COLS);
  endfunction

  // Logical-to-physical row by a single conditional subtract: y and offs are both < TEXT_ROWS.
  function automatic logic [ADDR_BITS-1:0] cell_addr(input logic [XW-1:0] x,
                                                     input logic [YW-1:0] y,
                                                     input logic [YW-1:0] offs);
    logic [YW:0] phys;
    phys = {1'b0, y} + {1'b0, offs};
    if (phys >= (YW+1)'(TEXT_ROWS)) phys = phys - (YW+1)'(TEXT_ROWS);
    return row_base(phys[YW-1:0]) + ADDR_BITS'(x);
  endfunction

  assign accept    = (state_q == S_IDLE) && ready_q && in_char_valid;
  assign is_print  = (in_char >= CHAR_BITS'('h20)) && (in_char <= CHAR_BITS'('h7E));
  assign is_lf     = (in_char == CHAR_BITS'('h0A));
  assign is_cr     = (in_char == CHAR_BITS'('h0D));
  assign is_bs     = (in_char == CHAR_BITS'('h08));
  assign at_eol    = (x_q == XW'(TEXT_COLS - 1));
  assign at_bottom = (y_q == YW'(TEXT_ROWS - 1));
  assign offs_inc  = (offs_q == YW'(TEXT_ROWS - 1)) ? '0 : offs_q + YW'(1);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= S_CLR_ALL;
      cnt_q    <= '0;
      base_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      offs_q   <= '0;
      scroll_q <= 1'b0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      x_q      <= x_d;
      y_q      <= y_d;
      offs_q   <= offs_d;
      scroll_q <= scroll_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
    end
  end

  // cnt_q is the next clear index to issue; the first line-clear write goes out on entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    x_d      = x_q;
    y_d      = y_q;
    offs_d   = offs_q;
    scroll_d = scroll_q;
    case (state_q)
      S_CLR_ALL: begin
        cnt_d = cnt_q + ADDR_BITS'(1);
        if (cnt_q == ADDR_BITS'(CELLS - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        if (accept) begin
          if (is_print) begin
            state_d  = S_WR;
            scroll_d = at_eol && at_bottom;
            x_d      = at_eol ? '0 : x_q + XW'(1);
            if (at_eol && !at_bottom) y_d = y_q + YW'(1);
            if (at_eol && at_bottom) begin
              offs_d = offs_inc;
              base_d = row_base(offs_q);
            end
          end else if (is_lf) begin
            if (!at_bottom) begin
              y_d = y_q + YW'(1);
            end else begin
              offs_d  = offs_inc;
              base_d  = row_base(offs_q);
              state_d = S_CLR_LINE;
              cnt_d   = ADDR_BITS'(1);
            end
          end else if (is_cr) begin
            x_d = '0;
          end else if (is_bs && (x_q != '0)) begin
            x_d      = x_q - XW'(1);
            state_d  = S_WR;
            scroll_d = 1'b0;
          end
        end
      end
      S_WR: begin
        scroll_d = 1'b0;
        if (scroll_q) begin
          state_d = S_CLR_LINE;
          cnt_d   = ADDR_BITS'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR_LINE: begin
        cnt_d = cnt_q + ADDR_BITS'(1);
        if (cnt_q == ADDR_BITS'(TEXT_COLS - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_CLR_ALL;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_CLR_ALL: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
        addr_d = cnt_q;
        data_d = CLEAR_CHAR;
      end
      S_IDLE: begin
        if (accept && is_print) begin
          we_d   = 1'b1;
          addr_d = cell_addr(x_q, y_q, offs_q);
          data_d = in_char;
        end else if (accept && is_bs && (x_q != '0)) begin
          we_d   = 1'b1;
          addr_d = cell_addr(x_q - XW'(1), y_q, offs_q);
          data_d = CLEAR_CHAR;
        end else if (accept && is_lf && at_bottom) begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          addr_d = row_base(offs_q);
          data_d = CLEAR_CHAR;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_WR: begin
        if (scroll_q) begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          addr_d = base_q;
          data_d = CLEAR_CHAR;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_CLR_LINE: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
        addr_d = base_q + cnt_q;
        data_d = CLEAR_CHAR;
      end
      default: ;
    endcase
  end

  assign out_char_ready = ready_q;
  assign out_mem_we     = we_q;
  assign out_mem_addr   = addr_q;
  assign out_mem_data   = data_q;
  assign out_cursor_x   = x_q;
  assign out_cursor_y   = y_q;
  assign out_row_offs   = offs_q;
  assign out_busy       = busy_q;
endmodule
